// File: rtl/bus_pkg.sv
// Shared types for the single-channel valid/ready request/response bus.
// req_t captures one request at the bus default widths.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } bus_state_e;

  localparam int ERR_CNT_W  = 16;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 8;

  typedef struct packed {
    logic                      write;
    logic [BUS_ADDR_W-1:0]     addr;
    logic [BUS_DATA_W-1:0]     wdata;
    logic [BUS_DATA_W/8-1:0]   wstrb;
  } req_t;

endpackage

// File: rtl/bus_mem.sv
// Word memory with per-byte write enables and a registered read port.
// Each byte lane is its own array so each lane maps onto a plain block RAM.
module bus_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_q [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (we && wstrb[gi]) begin
          lane_q[addr] <= wdata[gi*8 +: 8];
        end
        if (re) begin
          rd_q <= lane_q[addr];
        end
      end

      assign rdata[gi*8 +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/bus_responder.sv
// Responder end of the valid/ready bus: one request at a time, serviced from
// a byte-enabled memory after WAIT_CYCLES wait states.
module bus_responder
  import bus_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [DATA_W/8-1:0]  req_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int              NB        = DATA_W / 8;
  localparam int              MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  bus_state_e                 state_q, state_d;
  logic                       write_q, write_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic [NB-1:0]              wstrb_q, wstrb_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       rsp_err_q, rsp_err_d;
  logic                       rd_ok_q, rd_ok_d;
  logic [ERR_CNT_W-1:0]       err_count_q, err_count_d;

  logic                       accept;
  logic                       commit;
  logic                       c_write;
  logic [ADDR_W-1:0]          c_addr;
  logic [DATA_W-1:0]          c_wdata;
  logic [NB-1:0]              c_wstrb;
  logic                       in_range;
  logic [DATA_W-1:0]          mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
      rd_ok_q     <= rd_ok_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && !rst;
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_err_q;
    rsp_rdata = rd_ok_q ? mem_rdata : '0;
    err_count = err_count_q;
  end

  // With zero wait states the commit edge is the accept edge itself, so the
  // operands come straight from the bus instead of the capture registers.
  always_comb begin
    accept   = req_valid && req_ready;
    commit   = (state_d == RESP) && (state_q != RESP);
    c_write  = (state_q == IDLE) ? req_write : write_q;
    c_addr   = (state_q == IDLE) ? req_addr  : addr_q;
    c_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
    c_wstrb  = (state_q == IDLE) ? req_wstrb : wstrb_q;
    in_range = {1'b0, c_addr} < DEPTH_L;
  end

  always_comb begin
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
    rd_ok_d     = rd_ok_q;
    err_count_d = err_count_q;
    if (accept) begin
      write_d = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      wstrb_d = req_wstrb;
      cnt_d   = WAIT_LOAD;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (commit) begin
      rsp_err_d = !in_range;
      rd_ok_d   = in_range && !c_write;
      if (!in_range && err_count_q != '1) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end else if (state_q == RESP && rsp_ready) begin
      rsp_err_d = 1'b0;
      rd_ok_d   = 1'b0;
    end
  end

  bus_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (commit && in_range && c_write),
    .re    (commit && in_range && !c_write),
    .addr  (c_addr[MEM_AW-1:0]),
    .wdata (c_wdata),
    .wstrb (c_wstrb),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: a vector table of request/response pairs
// plus hand-written reset, backpressure and idle-ready sequences.
`timescale 1ns/1ps
module tb_bus_responder;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  bus_responder #(
    .DATA_W      (32),
    .ADDR_W      (8),
    .DEPTH       (64),
    .WAIT_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .err_count (err_count)
  );

  typedef struct {
    req_t        req;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NVEC    = 12;
  localparam int EXP_LAT = 3;

  vec_t vecs [NVEC];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int hold, input logic [31:0] rd,
                              input logic er, input logic [15:0] cnt);
    vec_t v;
    v.req.write = wr;
    v.req.addr  = a;
    v.req.wdata = d;
    v.req.wstrb = s;
    v.hold      = hold;
    v.exp_rdata = rd;
    v.exp_err   = er;
    v.exp_cnt   = cnt;
    return v;
  endfunction

  // Issue one request, wait for its response (holding rsp_ready low for
  // 'hold' cycles while poking a stray request), then complete the handshake.
  task automatic txn(input req_t r, input int hold, input logic [31:0] exp_rd,
                     output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", 32'(n < 20), 32'd1);
    req_valid = 1'b1;
    req_write = r.write;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    req_wstrb = r.wstrb;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'h05;
      req_wdata = 32'h0;
      req_wstrb = 4'hF;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rd = rsp_rdata;
    er = rsp_err;
    check("ready_in_resp", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("valid_after_hs", 32'(rsp_valid), 32'd0);
    check("ready_after_hs", 32'(req_ready), 32'd1);
    $display("txn %s addr=0x%02h wdata=0x%08h wstrb=0x%h -> rdata=0x%08h err=%0d lat=%0d err_count=%0d",
             r.write ? "WR" : "RD", r.addr, r.wdata, r.wstrb, rd, er, lat, err_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          vcount;
    req_t        r;

    vecs[0]  = mk(1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0, 16'd0);
    vecs[1]  = mk(1'b0, 8'h05, 32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0, 16'd0);
    vecs[2]  = mk(1'b1, 8'h05, 32'h11223344, 4'h5, 0, 32'h0,        1'b0, 16'd0);
    vecs[3]  = mk(1'b0, 8'h05, 32'h0,        4'h0, 5, 32'hDE22BE44, 1'b0, 16'd0);
    vecs[4]  = mk(1'b0, 8'h40, 32'h0,        4'h0, 0, 32'h0,        1'b1, 16'd1);
    vecs[5]  = mk(1'b1, 8'hFF, 32'h12345678, 4'hF, 0, 32'h0,        1'b1, 16'd2);
    vecs[6]  = mk(1'b0, 8'h05, 32'h0,        4'h0, 0, 32'hDE22BE44, 1'b0, 16'd2);
    vecs[7]  = mk(1'b1, 8'h05, 32'hFFFFFFFF, 4'h0, 0, 32'h0,        1'b0, 16'd2);
    vecs[8]  = mk(1'b0, 8'h05, 32'h0,        4'h0, 0, 32'hDE22BE44, 1'b0, 16'd2);
    vecs[9]  = mk(1'b1, 8'h3F, 32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0, 16'd2);
    vecs[10] = mk(1'b0, 8'h3F, 32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0, 16'd2);
    vecs[11] = mk(1'b1, 8'h07, 32'h00000000, 4'hF, 0, 32'h0,        1'b0, 16'd2);

    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", 32'(req_ready), 32'd0);
    check("valid_in_reset", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check("valid_after_reset", 32'(rsp_valid), 32'd0);
    check("cnt_after_reset", 32'(err_count), 32'd0);
    check("rdata_after_reset", rsp_rdata, 32'd0);
    check("err_after_reset", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      txn(vecs[i].req, vecs[i].hold, vecs[i].exp_rdata, rd, er, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(EXP_LAT));
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_cnt", i), 32'(err_count), 32'(vecs[i].exp_cnt));
    end

    // rsp_ready while idle must not conjure a response
    rsp_ready = 1'b1;
    vcount = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) vcount++;
    end
    rsp_ready = 1'b0;
    check("idle_rsp_ready_valid", 32'(vcount), 32'd0);
    check("idle_rsp_ready_ready", 32'(req_ready), 32'd1);
    $display("seq idle rsp_ready: spurious valids=%0d", vcount);

    // Reset during the first wait-state cycle discards the write
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h07;
    req_wdata = 32'hA5A5A5A5;
    req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstwait_cnt", 32'(err_count), 32'd0);
    check("rstwait_ready", 32'(req_ready), 32'd1);
    vcount = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) vcount++;
    end
    check("rstwait_no_valid", 32'(vcount), 32'd0);
    $display("seq reset-in-wait: valids after reset=%0d err_count=%0d", vcount, err_count);

    r.write = 1'b0;
    r.addr  = 8'h07;
    r.wdata = 32'h0;
    r.wstrb = 4'h0;
    txn(r, 0, 32'h0, rd, er, lat);
    check("rstwait_read_rdata", rd, 32'h00000000);
    check("rstwait_read_err", 32'(er), 32'd0);
    check("rstwait_read_lat", 32'(lat), 32'(EXP_LAT));

    r.addr = 8'h80;
    txn(r, 0, 32'h0, rd, er, lat);
    check("post_rst_oor_err", 32'(er), 32'd1);
    check("post_rst_oor_cnt", 32'(err_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
